// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared constants and the dead-time FSM state type for the
//            triangle-carrier PWM modulator.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    // Largest magnitude the triangle table returns.
    localparam int TRI_PEAK = 364;
    // Signed sample / reference width.
    localparam int TRI_W    = 10;
    // Phase index width toward the triangle table.
    localparam int THETA_W  = 8;

    // Dead-time FSM states.
    typedef enum logic [1:0] {
        OFF  = 2'd0,
        DEAD = 2'd1,
        H_ON = 2'd2,
        L_ON = 2'd3
    } dt_state_e;

endpackage
`default_nettype wire

// File: rtl/pwm_dead_time.sv
`default_nettype none
// ============================================================================
// Module   : pwm_dead_time
// Purpose  : Turns the registered compare decision into a complementary gate
//            pair with a programmable both-low gap on every side change.
// Ports    : clk_i        - clock, rising edge
//            rst_i        - synchronous active-high reset
//            en_i         - enable; low forces OFF (both gates low)
//            raw_i        - registered compare decision (1 = high side)
//            dead_time_i  - dead-time length in clocks
//            pwm_h_o      - high-side gate, registered
//            pwm_l_o      - low-side gate, registered
// Revision : 1.0 - initial release
// ============================================================================
module pwm_dead_time
    import pwm_pkg::*;
#(
    parameter int DT_W = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic            raw_i,
    input  logic [DT_W-1:0] dead_time_i,
    output logic            pwm_h_o,
    output logic            pwm_l_o
);

    dt_state_e       state_q;
    logic [DT_W-1:0] cnt_q;
    logic            target_q;
    logic            pwm_h_q;
    logic            pwm_l_q;

    logic            dt_zero;
    logic [DT_W-1:0] dt_reload;
    logic            change;

    assign dt_zero   = (dead_time_i == '0);
    // The cycle of entering DEAD is itself the first both-low cycle, so the
    // counter starts one short and the gate rises on the cycle after zero.
    assign dt_reload = dead_time_i - DT_W'(1);
    // OFF behaves as if the decision just changed, so leaving OFF shares the
    // same path as a normal side change. In H_ON/L_ON target_q is the side held.
    assign change    = (state_q == OFF) || (raw_i != target_q);

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            state_q  <= OFF;
            cnt_q    <= '0;
            target_q <= 1'b0;
            pwm_h_q  <= 1'b0;
            pwm_l_q  <= 1'b0;
        end else if (change) begin
            target_q <= raw_i;
            if (dt_zero) begin
                state_q <= raw_i ? H_ON : L_ON;
                pwm_h_q <= raw_i;
                pwm_l_q <= !raw_i;
            end else begin
                state_q <= DEAD;
                cnt_q   <= dt_reload;
                pwm_h_q <= 1'b0;
                pwm_l_q <= 1'b0;
            end
        end else if (state_q == DEAD) begin
            if (cnt_q == '0) begin
                state_q <= target_q ? H_ON : L_ON;
                pwm_h_q <= target_q;
                pwm_l_q <= !target_q;
            end else begin
                cnt_q <= cnt_q - DT_W'(1);
            end
        end
    end

    assign pwm_h_o = pwm_h_q;
    assign pwm_l_o = pwm_l_q;

endmodule
`default_nettype wire

// File: rtl/pwm_tri_modulator.sv
`default_nettype none
// ============================================================================
// Module   : pwm_tri_modulator
// Purpose  : Triangle-carrier PWM modulator. A phase accumulator drives the
//            external triangle table; the returned sample is compared with a
//            double-buffered duty reference and fed to the dead-time stage.
// Ports    : clk_i        - clock, rising edge
//            rst_i        - synchronous active-high reset
//            en_i         - modulator enable
//            freq_word_i  - phase increment per clock
//            dead_time_i  - dead-time length in clocks
//            ref_i        - signed duty reference
//            ref_valid_i  - reference offered
//            ref_ready_o  - shadow register free
//            theta_o      - phase to the triangle table, registered
//            tri_in_i     - signed triangle sample for theta_o
//            pwm_h_o      - high-side gate
//            pwm_l_o      - low-side gate
//            sync_o       - one-clock pulse at carrier period start
// Revision : 1.0 - initial release
// ============================================================================
module pwm_tri_modulator
    import pwm_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int DT_W  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic [ACC_W-1:0]        freq_word_i,
    input  logic [DT_W-1:0]         dead_time_i,
    input  logic signed [TRI_W-1:0] ref_i,
    input  logic                    ref_valid_i,
    output logic                    ref_ready_o,
    output logic [THETA_W-1:0]      theta_o,
    input  logic signed [TRI_W-1:0] tri_in_i,
    output logic                    pwm_h_o,
    output logic                    pwm_l_o,
    output logic                    sync_o
);

    // ------------------------------------------------------------------
    // Phase accumulator; the carry out marks the start of a carrier period
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] acc_q;
    logic             sync_q;
    logic [ACC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc_q} + {1'b0, freq_word_i};

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            acc_q  <= '0;
            sync_q <= 1'b0;
        end else begin
            acc_q  <= acc_sum[ACC_W-1:0];
            sync_q <= acc_sum[ACC_W];
        end
    end

    assign theta_o = acc_q[ACC_W-1 -: THETA_W];
    assign sync_o  = sync_q;

    // ------------------------------------------------------------------
    // Reference double buffer: accepted values wait in the shadow and
    // only become active on a period boundary, so a carrier period never
    // sees two different duties.
    // ------------------------------------------------------------------
    logic signed [TRI_W-1:0] shadow_q;
    logic signed [TRI_W-1:0] ref_act_q;
    logic                    pending_q;
    logic                    xfer;

    assign xfer        = ref_valid_i && !pending_q;
    assign ref_ready_o = !pending_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q  <= '0;
            ref_act_q <= '0;
            pending_q <= 1'b0;
        end else if (xfer) begin
            // Lands in the shadow even on a SYNC cycle; applies next period.
            shadow_q  <= ref_i;
            pending_q <= 1'b1;
        end else if (sync_q && pending_q) begin
            ref_act_q <= shadow_q;
            pending_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Compare pipeline. The triangle range is +/-TRI_PEAK so references
    // beyond it saturate naturally without extra clamping.
    // ------------------------------------------------------------------
    logic signed [TRI_W-1:0] tri_q;
    logic                    raw_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tri_q <= '0;
            raw_q <= 1'b0;
        end else begin
            tri_q <= tri_in_i;
            raw_q <= (ref_act_q > tri_q);
        end
    end

    pwm_dead_time #(
        .DT_W (DT_W)
    ) u_dead_time (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .raw_i       (raw_q),
        .dead_time_i (dead_time_i),
        .pwm_h_o     (pwm_h_o),
        .pwm_l_o     (pwm_l_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_pwm_tri_modulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_tri_modulator
// Purpose  : Self-checking bench for pwm_tri_modulator with a behavioural
//            triangle table, a reference model and a scoreboard queue.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_tri_modulator;

    localparam int ACC_W = 16;
    localparam int DT_W  = 8;

    logic              clk;
    logic              rst;
    logic              en;
    logic [ACC_W-1:0]  fw;
    logic [DT_W-1:0]   dt;
    logic signed [9:0] refv;
    logic              ref_valid;
    logic              ref_ready;
    logic [7:0]        theta;
    logic signed [9:0] tri_in;
    logic              pwm_h;
    logic              pwm_l;
    logic              sync;

    // Override lets the bench force arbitrary compare decisions.
    logic              ovr_en;
    logic signed [9:0] ovr_val;

    int total;
    int bad;

    // Triangle table: -364 at phase 0, +364 at phase 128, symmetric.
    function automatic int tri_of(input int t);
        if (t < 128) return -364 + (t * 91) / 16;
        return 364 - ((t - 128) * 91) / 16;
    endfunction

    assign tri_in = ovr_en ? ovr_val : 10'(tri_of(int'(theta)));

    pwm_tri_modulator #(
        .ACC_W (ACC_W),
        .DT_W  (DT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .freq_word_i (fw),
        .dead_time_i (dt),
        .ref_i       (refv),
        .ref_valid_i (ref_valid),
        .ref_ready_o (ref_ready),
        .theta_o     (theta),
        .tri_in_i    (tri_in),
        .pwm_h_o     (pwm_h),
        .pwm_l_o     (pwm_l),
        .sync_o      (sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] theta;
        logic       sync;
        logic       h;
        logic       l;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];

    // ---------------- reference model state (after each edge) -----------
    int m_acc, m_sync, m_pend, m_shadow, m_act, m_triq, m_raw;
    int m_run, m_seen, m_since, m_h, m_l;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // One clock of the model using the inputs currently applied.
    task automatic model_step();
        int   tri_now;
        int   sum;
        exp_t e;
        tri_now = ovr_en ? int'(ovr_val) : tri_of(m_acc >> 8);
        if (rst) begin
            m_acc = 0; m_sync = 0; m_pend = 0; m_shadow = 0; m_act = 0;
            m_triq = 0; m_raw = 0; m_run = 0; m_seen = 0; m_since = 0;
            m_h = 0; m_l = 0;
        end else begin
            // Gate side follows the decision once it has been stable for
            // more than dt clocks since it last changed (or since enable).
            if (!en) begin
                m_run = 0; m_h = 0; m_l = 0;
            end else begin
                if (m_run == 0 || m_raw != m_seen) m_since = 1;
                else if (m_since < 100000) m_since++;
                m_run  = 1;
                m_seen = m_raw;
                if (m_since >= int'(dt) + 1) begin
                    m_h = m_raw; m_l = 1 - m_raw;
                end else begin
                    m_h = 0; m_l = 0;
                end
            end
            m_raw  = (m_act > m_triq) ? 1 : 0;
            m_triq = tri_now;
            if (m_sync == 1 && m_pend == 1) begin
                m_act  = m_shadow;
                m_pend = 0;
            end else if (ref_valid && m_pend == 0) begin
                m_shadow = int'(refv);
                m_pend   = 1;
            end
            if (en) begin
                sum    = m_acc + int'(fw);
                m_sync = (sum >= 65536) ? 1 : 0;
                m_acc  = sum % 65536;
            end else begin
                m_acc = 0; m_sync = 0;
            end
        end
        e.theta = 8'(m_acc >> 8);
        e.sync  = (m_sync != 0);
        e.h     = (m_h != 0);
        e.l     = (m_l != 0);
        e.ready = (m_pend == 0);
        exp_q.push_back(e);
    endtask

    // Issue one clock of stimulus: predict, then let the edge happen.
    task automatic cycle();
        model_step();
        @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("theta",     int'(theta),     int'(e.theta));
                chk("sync",      int'(sync),      int'(e.sync));
                chk("pwm_h",     int'(pwm_h),     int'(e.h));
                chk("pwm_l",     int'(pwm_l),     int'(e.l));
                chk("ref_ready", int'(ref_ready), int'(e.ready));
                chk("overlap",   int'(pwm_h & pwm_l), 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int len;
        int r;
        total = 0; bad = 0;
        ovr_en = 1'b0; ovr_val = '0;
        // Reset held with enable and a pending offer present.
        rst = 1'b1; en = 1'b1; ref_valid = 1'b1; refv = 10'sd123;
        fw = 16'h0100; dt = '0;
        repeat (3) cycle();

        // Free-run, 50% duty, no dead time.
        rst = 1'b0; ref_valid = 1'b0; refv = '0;
        repeat (600) cycle();

        // Dead time 5 with the real table.
        en = 1'b0; cycle();
        dt = 8'd5; en = 1'b1;
        repeat (600) cycle();

        // Forced decision sequences with short glitches during DEAD.
        ovr_en = 1'b1;
        repeat (80) begin
            len = $urandom_range(1, 9);
            ovr_val = ($urandom_range(0, 1) != 0) ? 10'sd1 : -10'sd1;
            repeat (len) cycle();
        end
        ovr_en = 1'b0;

        // Handshake: accept 200 mid-period, second offer while pending ignored.
        repeat (100) cycle();
        refv = 10'sd200; ref_valid = 1'b1; cycle();
        refv = -10'sd50;  repeat (20) cycle();
        ref_valid = 1'b0; repeat (500) cycle();

        // Saturation both ways.
        refv = 10'sd400;  ref_valid = 1'b1; cycle();
        ref_valid = 1'b0; repeat (600) cycle();
        refv = -10'sd400; ref_valid = 1'b1; cycle();
        ref_valid = 1'b0; repeat (600) cycle();

        // Randomized references, different carrier and dead time.
        en = 1'b0; cycle();
        dt = 8'd3; fw = 16'h0333; en = 1'b1;
        repeat (2000) begin
            ref_valid = ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 800)) - 400;
            refv = 10'(r);
            en = ($urandom_range(0, 199) != 0);
            cycle();
        end
        en = 1'b1; ref_valid = 1'b0;

        // Disable and resync mid-period.
        fw = 16'h0100;
        repeat (77) cycle();
        en = 1'b0; repeat (3) cycle();
        en = 1'b1; repeat (300) cycle();

        // Reset mid-period clears the active reference too.
        refv = 10'sd300; ref_valid = 1'b1; cycle();
        ref_valid = 1'b0; repeat (300) cycle();
        rst = 1'b1; cycle();
        rst = 1'b0; repeat (300) cycle();

        // Zero frequency word freezes phase, no SYNC.
        fw = '0; repeat (100) cycle();

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
